// File: rtl/otter_test_ctrl.sv
// otter_test_ctrl: OTTER core reset sequencing and tohost pass/fail/timeout monitor.
// Optional OTTER_TEST_CTRL_INSTRET_EN adds a retired-instruction counter.
module otter_test_ctrl #(
    parameter int unsigned RST_CYCLES = 20,
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_1000)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MEM_WE,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DIN,
`ifdef OTTER_TEST_CTRL_INSTRET_EN
    input  logic              INSTRET,
    output logic [31:0]       INSTRET_COUNT,
`endif
    output logic              CPU_RST,
    output logic              DONE,
    output logic              PASS,
    output logic              TIMEOUT,
    output logic [DATA_W-2:0] FAIL_CODE,
    output logic [31:0]       CYCLE_COUNT
);
    localparam logic [1:0] HOLD = 2'd0, RUN = 2'd1, FINISHED = 2'd2;
    localparam logic [15:0] HOLD_LAST = 16'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [1:0] state;
    logic [15:0] hold_cnt;
    logic hit, pass_hit, fail_hit, expire;
    always_comb begin
        hit = state == RUN && MEM_WE && MEM_ADDR == TOHOST_ADDR;
        pass_hit = hit && MEM_DIN == DATA_W'(1);
        // unsigned value above 1 excludes both the ignored 0 and the pass 1
        fail_hit = hit && MEM_DIN > DATA_W'(1);
        expire = state == RUN && CYCLE_COUNT == TO_LAST;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= HOLD;
            hold_cnt <= '0;
            CYCLE_COUNT <= '0;
            DONE <= 1'b0;
            PASS <= 1'b0;
            TIMEOUT <= 1'b0;
            FAIL_CODE <= '0;
            CPU_RST <= 1'b1;
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + 16'd1;
            if (hold_cnt == HOLD_LAST) begin
                state <= RUN;
                CPU_RST <= 1'b0;
            end
        end else if (state == RUN) begin
            if (pass_hit || fail_hit || expire) begin
                state <= FINISHED;
                CPU_RST <= 1'b1;
                DONE <= 1'b1;
                PASS <= pass_hit;
                TIMEOUT <= !pass_hit && !fail_hit;
                FAIL_CODE <= fail_hit ? MEM_DIN[DATA_W-1:1] : '0;
            end else if (CYCLE_COUNT != '1) begin
                CYCLE_COUNT <= CYCLE_COUNT + 32'd1;
            end
        end
    end
`ifdef OTTER_TEST_CTRL_INSTRET_EN
    always_ff @(posedge CLK) begin
        if (RST)
            INSTRET_COUNT <= '0;
        else if (state == RUN && INSTRET && INSTRET_COUNT != '1)
            INSTRET_COUNT <= INSTRET_COUNT + 32'd1;
    end
`endif
endmodule

// File: doc/otter_test_ctrl.md
OTTER_TEST_CTRL -- requirements
Module: otter_test_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 20: number of CLK cycles CPU_RST is held after RST deasserts; legal range 1..2^16-1.
REQ-002 Parameter TIMEOUT_CYCLES, default 100: RUN-state cycle limit before timeout; legal range 1..2^32-1.
REQ-003 Parameter TOHOST_ADDR, default 32'h0000_1000: word address whose writes end the test.
REQ-004 Parameter ADDR_W, default 32: monitored bus address width.
REQ-005 Parameter DATA_W, default 32: monitored bus data width, minimum 2.
REQ-006 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-007 RST  input  1  synchronous, active-high reset.
REQ-008 MEM_WE  input  1  CPU data-bus write strobe, one cycle per write.
REQ-009 MEM_ADDR  input  ADDR_W  CPU data-bus address, valid when MEM_WE=1.
REQ-010 MEM_DIN  input  DATA_W  CPU data-bus write data, valid when MEM_WE=1.
REQ-011 CPU_RST  output  1  reset driven to the OTTER core.
REQ-012 DONE  output  1  test finished (pass, fail or timeout); sticky.
REQ-013 PASS  output  1  test finished with tohost value 1; sticky.
REQ-014 TIMEOUT  output  1  test finished by cycle limit; sticky.
REQ-015 FAIL_CODE  output  DATA_W-1  MEM_DIN[DATA_W-1:1] of the failing tohost write; 0 otherwise.
REQ-016 CYCLE_COUNT  output  32  RUN-state cycle count.

Function
REQ-017 FSM states: HOLD, RUN, FINISHED; no other reachable states.
REQ-018 HOLD: CPU_RST=1, hold counter increments each cycle; transition to RUN on the cycle the counter reaches RST_CYCLES-1, so CPU_RST is high for exactly RST_CYCLES cycles after RST falls.
REQ-019 RUN: CPU_RST=0, CYCLE_COUNT increments by 1 per cycle starting from 0 on the first RUN cycle.
REQ-020 Tohost hit = MEM_WE=1 and MEM_ADDR==TOHOST_ADDR, full ADDR_W compare, evaluated only in RUN.
REQ-021 Hit with MEM_DIN==1: next cycle FINISHED, DONE=1, PASS=1, FAIL_CODE=0.
REQ-022 Hit with MEM_DIN==0: ignored, remain in RUN.
REQ-023 Hit with any other MEM_DIN: next cycle FINISHED, DONE=1, PASS=0, FAIL_CODE=MEM_DIN[DATA_W-1:1].
REQ-024 When CYCLE_COUNT==TIMEOUT_CYCLES-1 with no hit that cycle: next cycle FINISHED, DONE=1, TIMEOUT=1, PASS=0.
REQ-025 Hit and timeout in the same cycle: hit wins; TIMEOUT stays 0.
REQ-026 FINISHED: CPU_RST=1 (core frozen), CYCLE_COUNT frozen, all status outputs held; bus inputs ignored; exit only via RST.
REQ-027 Writes or strobes during HOLD are ignored.
REQ-028 CYCLE_COUNT saturates at 32'hFFFF_FFFF, never wraps.
REQ-029 All outputs registered; no combinational path from MEM_* to any output.

Reset
REQ-030 RST=1 on any edge, in any state: state<=HOLD, hold counter<=0, CYCLE_COUNT<=0, DONE/PASS/TIMEOUT<=0, FAIL_CODE<=0, CPU_RST<=1.
REQ-031 Reset mid-RUN or in FINISHED discards results; sequence restarts with a full RST_CYCLES hold after RST falls.

Configuration
REQ-032 Macro OTTER_TEST_CTRL_INSTRET_EN defined: adds input INSTRET (1 bit, one pulse per retired instruction) and output INSTRET_COUNT (32 bits), counting INSTRET pulses in RUN only, saturating, frozen in FINISHED, reset to 0 by RST.
REQ-033 Macro undefined: INSTRET and INSTRET_COUNT do not exist; all other behaviour identical.

Verification
REQ-034 RST high 5 cycles then low, RST_CYCLES=20 -> CPU_RST high exactly 20 cycles after RST falls, then 0; CYCLE_COUNT=0 on first RUN cycle.
REQ-035 In RUN, write 1 to 0x1000 at CYCLE_COUNT=37 -> next cycle DONE=1, PASS=1, CPU_RST=1, CYCLE_COUNT held at 37.
REQ-036 Write 0x0000_000B to 0x1000 -> DONE=1, PASS=0, FAIL_CODE=5; prior write of 0 to 0x1000 and write of 1 to 0x1004 -> no effect.
REQ-037 TIMEOUT_CYCLES=100, no writes -> DONE=1, TIMEOUT=1 one cycle after CYCLE_COUNT=99; variant with pass write at CYCLE_COUNT=99 -> PASS=1, TIMEOUT=0.
REQ-038 RST pulsed for 1 cycle mid-RUN at CYCLE_COUNT=50, then pass write at 0x1000 during HOLD -> all status 0, write ignored, fresh 20-cycle hold, CYCLE_COUNT restarts at 0.
REQ-039 With OTTER_TEST_CTRL_INSTRET_EN, 10 INSTRET pulses during HOLD and 7 during RUN before pass write -> INSTRET_COUNT=7, unchanged after DONE.
